// File: rtl/rv32i_mem_pkg.sv
// +--------------------------------------------------------------------+
// | rv32i_mem_pkg                                                      |
// | Shared load/store size encodings, responder state type, helpers.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package rv32i_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_lsu_align.sv
// +--------------------------------------------------------------------+
// | rv32i_lsu_align                                                    |
// | Byte-lane enables, store-data replication and load extension.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rv32i_lsu_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] w_shift;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    // Halfword accesses are only legal on even addresses, so the same shift serves both sizes.
    w_shift    = rdata_raw >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~ld_unsigned & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~ld_unsigned & w_shift[15]}}, w_shift[15:0]};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_dmem_responder.sv
// +--------------------------------------------------------------------+
// | rv32i_dmem_responder                                               |
// | Data-memory target for the core load/store port, with wait states. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          c_aw        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_span      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  c_wait_load = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_t r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;

  logic        r_we, r_uns;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_exec, w_we, w_uns, w_err;
  logic [31:0] w_addr, w_wdata, w_off, w_raw, w_lane, w_ext;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [c_aw-1:0] w_idx;

  logic [31:0] r_mem [DEPTH_WORDS];

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = c_wait_load;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && req_valid) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_wdata <= req_wdata;
    end
  end

  // With zero wait states the access happens on the accept edge, before the latch is loaded.
  assign w_exec  = (w_next == RESP) && (r_state != RESP);
  assign w_we    = (r_state == IDLE) ? req_we       : r_we;
  assign w_addr  = (r_state == IDLE) ? req_addr     : r_addr;
  assign w_size  = (r_state == IDLE) ? req_size     : r_size;
  assign w_uns   = (r_state == IDLE) ? req_unsigned : r_uns;
  assign w_wdata = (r_state == IDLE) ? req_wdata    : r_wdata;

  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = w_off[c_aw+1:2];
  assign w_raw = r_mem[w_idx];
  assign w_err = (w_size == SZ_ILL) || misaligned(w_size, w_addr[1:0]) || ({1'b0, w_off} >= c_span);

  rv32i_lsu_align u_align (
    .size        (w_size),
    .addr_lo     (w_addr[1:0]),
    .ld_unsigned (w_uns),
    .wdata       (w_wdata),
    .rdata_raw   (w_raw),
    .be          (w_be),
    .wdata_lane  (w_lane),
    .rdata_ext   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst && w_exec && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_we) ? 32'h0 : w_ext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem_responder.sv
// +--------------------------------------------------------------------+
// | tb_rv32i_dmem_responder                                            |
// | Directed vector bench: two responders, 2 and 0 wait states.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rv32i_dmem_responder;
  import rv32i_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv2, rv0, rr2, rr0, vv2, vv0, er2, er0;
  logic        req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata, rd2, rd0;
  logic [1:0]  req_size;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(vv2), .rsp_ready(rsp_ready),
    .rsp_rdata(rd2), .rsp_err(er2)
  );

  rv32i_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(vv0), .rsp_ready(rsp_ready),
    .rsp_rdata(rd0), .rsp_err(er0)
  );

  typedef struct {
    bit          sel;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic txn(input bit sel, input bit we, input logic [31:0] a, input logic [1:0] sz,
                     input bit u, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    if (sel) rv0 = 1'b1; else rv2 = 1'b1;
    guard = 0;
    while (!(sel ? rr0 : rr2) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    rv0 = 1'b0; rv2 = 1'b0;
    lat = 1;
    while (!(sel ? vv0 : vv2) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? rd0 : rd2;
    er = sel ? er0 : er2;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, hold;
    logic        er;
    int          lat;
    bit          stable;

    rst = 1'b1; rv2 = 1'b0; rv0 = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = 32'h0; req_size = SZ_WORD; req_unsigned = 1'b0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, rr2 | rr0}, 32'h0);
    chk("rst_rsp_valid", {31'h0, vv2 | vv0}, 32'h0);
    chk("rst_rdata", rd2 | rd0, 32'h0);
    chk("rst_err", {31'h0, er2 | er0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {30'h0, rr2, rr0}, 32'h3);

    vt.push_back('{0, 1, 32'h10, SZ_WORD, 0, 32'hDEADBEEF, 32'h0,        0, "sw_10"});
    vt.push_back('{0, 0, 32'h10, SZ_WORD, 0, 32'h0,        32'hDEADBEEF, 0, "lw_10"});
    vt.push_back('{0, 1, 32'h20, SZ_WORD, 0, 32'h80FF7F01, 32'h0,        0, "sw_20"});
    vt.push_back('{0, 0, 32'h22, SZ_BYTE, 0, 32'h0,        32'hFFFFFFFF, 0, "lb_22"});
    vt.push_back('{0, 0, 32'h23, SZ_BYTE, 1, 32'h0,        32'h00000080, 0, "lbu_23"});
    vt.push_back('{0, 0, 32'h21, SZ_BYTE, 0, 32'h0,        32'h0000007F, 0, "lb_21"});
    vt.push_back('{0, 0, 32'h20, SZ_HALF, 0, 32'h0,        32'h00007F01, 0, "lh_20"});
    vt.push_back('{0, 0, 32'h22, SZ_HALF, 1, 32'h0,        32'h000080FF, 0, "lhu_22"});
    vt.push_back('{0, 0, 32'h22, SZ_HALF, 0, 32'h0,        32'hFFFF80FF, 0, "lh_22"});
    vt.push_back('{0, 1, 32'h30, SZ_WORD, 0, 32'h11223344, 32'h0,        0, "sw_30"});
    vt.push_back('{0, 1, 32'h31, SZ_BYTE, 0, 32'h000000AA, 32'h0,        0, "sb_31"});
    vt.push_back('{0, 0, 32'h30, SZ_WORD, 0, 32'h0,        32'h1122AA44, 0, "lw_30_a"});
    vt.push_back('{0, 1, 32'h32, SZ_HALF, 0, 32'h00005566, 32'h0,        0, "sh_32"});
    vt.push_back('{0, 0, 32'h30, SZ_WORD, 0, 32'h0,        32'h5566AA44, 0, "lw_30_b"});
    vt.push_back('{0, 0, 32'h41, SZ_WORD, 0, 32'h0,        32'h0,        1, "lw_41"});
    vt.push_back('{0, 0, 32'h43, SZ_HALF, 0, 32'h0,        32'h0,        1, "lh_43"});
    vt.push_back('{0, 0, 32'h40, SZ_ILL,  0, 32'h0,        32'h0,        1, "size_11"});
    vt.push_back('{0, 0, 32'h1000, SZ_WORD, 0, 32'h0,      32'h0,        1, "lw_oob"});
    vt.push_back('{0, 1, 32'h40, SZ_WORD, 0, 32'hCAFEF00D, 32'h0,        0, "sw_40"});
    vt.push_back('{0, 1, 32'h42, SZ_WORD, 0, 32'h11111111, 32'h0,        1, "sw_42_mis"});
    vt.push_back('{0, 0, 32'h40, SZ_WORD, 0, 32'h0,        32'hCAFEF00D, 0, "lw_40"});
    vt.push_back('{0, 1, 32'h50, SZ_WORD, 0, 32'h0BADF00D, 32'h0,        0, "sw_50"});
    vt.push_back('{1, 1, 32'h60, SZ_WORD, 0, 32'h00000077, 32'h0,        0, "w0_sw_60"});
    vt.push_back('{1, 0, 32'h60, SZ_BYTE, 0, 32'h0,        32'h00000077, 0, "w0_lb_60"});
    vt.push_back('{1, 0, 32'hFFFFFFFC, SZ_WORD, 0, 32'h0,  32'h0,        1, "w0_lw_oob"});

    foreach (vt[i]) begin
      txn(vt[i].sel, vt[i].we, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata, rd, er, lat);
      chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_err"}, {31'h0, er}, {31'h0, vt[i].exp_err});
      chk({vt[i].name, "_lat"}, lat, vt[i].sel ? 32'd1 : 32'd3);
    end

    // Back-pressure: response held for 5 cycles while a competing store request is presented.
    rsp_ready = 1'b0;
    txn_start_lw : begin
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_size = SZ_WORD; req_unsigned = 1'b0; rv2 = 1'b1;
      @(posedge clk); #1;
      rv2 = 1'b0;
      lat = 1;
      while (!vv2 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("bp_lat", lat, 32'd3);
      hold = rd2;
      chk("bp_rdata", hold, 32'hDEADBEEF);
      @(negedge clk);
      req_we = 1'b1; req_wdata = 32'h99999999; rv2 = 1'b1;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (!vv2 || rd2 !== hold || rr2 || er2) stable = 1'b0;
      end
      chk("bp_stable", {31'h0, stable}, 32'h1);
      @(negedge clk);
      rv2 = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", {31'h0, vv2}, 32'h0);
      stable = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (vv2) stable = 1'b0;
      end
      chk("bp_single_rsp", {31'h0, stable}, 32'h1);
    end
    txn(0, 0, 32'h10, SZ_WORD, 0, 32'h0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'hDEADBEEF);

    // Reset while a store is still waiting: it must never commit or respond.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h50; req_size = SZ_WORD; req_wdata = 32'h12345678; rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0; rst = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (vv2) stable = 1'b0;
      if (k == 2) rst = 1'b0;
    end
    chk("rstwait_no_rsp", {31'h0, stable}, 32'h1);
    chk("rstwait_ready", {31'h0, rr2}, 32'h1);
    txn(0, 0, 32'h50, SZ_WORD, 0, 32'h0, rd, er, lat);
    chk("rstwait_lw_50", rd, 32'h0BADF00D);

    // Zero wait states: the store commits on the accept edge and survives a following reset.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h64; req_size = SZ_WORD; req_wdata = 32'hA5A5A5A5; rv0 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0;
    chk("w0_rsp_1cyc", {31'h0, vv0}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("w0_rst_valid", {31'h0, vv0}, 32'h0);
    rst = 1'b0;
    txn(1, 0, 32'h64, SZ_WORD, 0, 32'h0, rd, er, lat);
    chk("w0_committed", rd, 32'hA5A5A5A5);
    chk("w0_committed_lat", lat, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
